// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states, ALU operations and small decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } aluop_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        logic signed [15:0] imm_s;
        logic signed [31:0] ext_s;
        imm_s = imm;
        ext_s = 32'(imm_s);
        return ext_s;
    endfunction

    function automatic aluop_t funct_aluop(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_known(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: return funct inside {FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB,
                                           FN_AND, FN_OR, FN_SLT};
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the multi-cycle core; zero flag drives beq/bne.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  aluop_t      aluop,
    output logic [31:0] result,
    output logic        zero
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result = '0;
        case (aluop)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, (a_s < b_s)};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS-subset core with req/ready instruction and data ports.
// Optional MIPS_EXC_EN: unknown instructions trap to EXC_VECTOR, adds exc port and EPC (read as R26).
module multicycle_mips
    import mips_pkg::*;
#(
    parameter int          DMEM_AW    = 7,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               i_req,
    output logic [31:0]        i_addr,
    input  logic [31:0]        i_rdata,
    input  logic               i_ready,
    output logic               d_req,
    output logic               d_we,
    output logic [DMEM_AW-1:0] d_addr,
    output logic [31:0]        d_wdata,
    input  logic [31:0]        d_rdata,
    input  logic               d_ready,
    output logic               retire
`ifdef MIPS_EXC_EN
    ,
    output logic               exc
`endif
);

    state_t      state, state_next;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] regs [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];
    assign target = ir[25:0];

    logic [31:0] rs_val, rt_val;
    logic [31:0] pc_plus4, branch_target, jump_target;
    logic        known;

`ifdef MIPS_EXC_EN
    logic [31:0] epc;
    logic        epc_load;
    logic        exc_c;

    assign rs_val = (rs == 5'd26) ? epc : regs[rs];
    assign rt_val = (rt == 5'd26) ? epc : regs[rt];
`else
    logic unused_exc_vector;

    assign unused_exc_vector = ^EXC_VECTOR;
    assign rs_val = regs[rs];
    assign rt_val = regs[rt];
`endif

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc + (sext16(imm) << 2);
    assign jump_target   = {pc[31:28], target, 2'b00};
    assign known         = is_known(op, funct);

    // Operand select: R-type and branches compare registers, the rest add the immediate.
    logic [31:0] alu_b, alu_result;
    aluop_t      alu_op;
    logic        alu_zero;

    always_comb begin
        alu_b  = sext16(imm);
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                alu_b  = b;
                alu_op = funct_aluop(funct);
            end
            OP_BEQ, OP_BNE: begin
                alu_b  = b;
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    mips_alu u_alu (
        .a      (a),
        .b      (alu_b),
        .shamt  (shamt),
        .aluop  (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    logic        i_req_c, d_req_c, d_we_c, retire_c;
    logic        ir_load, pc_load, mdr_load, rf_we;
    logic [31:0] pc_next, rf_wdata;
    logic [4:0]  rf_waddr;

    always_comb begin
        state_next = state;
        i_req_c    = 1'b0;
        d_req_c    = 1'b0;
        d_we_c     = 1'b0;
        retire_c   = 1'b0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        pc_next    = pc;
        mdr_load   = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = rd;
        rf_wdata   = alu_out;
`ifdef MIPS_EXC_EN
        epc_load   = 1'b0;
        exc_c      = 1'b0;
`endif
        case (state)
            FETCH: begin
                i_req_c = 1'b1;
                if (i_ready) begin
                    ir_load    = 1'b1;
                    pc_load    = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (!known) begin
`ifdef MIPS_EXC_EN
                    exc_c    = 1'b1;
                    epc_load = 1'b1;
                    pc_load  = 1'b1;
                    pc_next  = EXC_VECTOR;
`else
                    retire_c = 1'b1;
`endif
                    state_next = FETCH;
                end else if (op == OP_J || op == OP_JAL) begin
                    pc_load    = 1'b1;
                    pc_next    = jump_target;
                    retire_c   = 1'b1;
                    state_next = FETCH;
                    if (op == OP_JAL) begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc;
                    end
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_load    = 1'b1;
                            pc_next    = a;
                            retire_c   = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        // alu_out still holds the target computed in DECODE
                        if (alu_zero == (op == OP_BEQ)) begin
                            pc_load = 1'b1;
                            pc_next = alu_out;
                        end
                        retire_c   = 1'b1;
                        state_next = FETCH;
                    end
                    OP_LW, OP_SW: state_next = MEM;
                    default:      state_next = WB;
                endcase
            end
            MEM: begin
                d_req_c = 1'b1;
                d_we_c  = (op == OP_SW);
                if (d_ready) begin
                    if (op == OP_SW) begin
                        retire_c   = 1'b1;
                        state_next = FETCH;
                    end else begin
                        mdr_load   = 1'b1;
                        state_next = WB;
                    end
                end
            end
            WB: begin
                rf_we      = 1'b1;
                retire_c   = 1'b1;
                state_next = FETCH;
                case (op)
                    OP_RTYPE: begin
                        rf_waddr = rd;
                        rf_wdata = alu_out;
                    end
                    OP_LW: begin
                        rf_waddr = rt;
                        rf_wdata = mdr;
                    end
                    default: begin
                        rf_waddr = rt;
                        rf_wdata = alu_out;
                    end
                endcase
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
`ifdef MIPS_EXC_EN
            epc     <= '0;
`endif
        end else begin
            state <= state_next;
            if (ir_load) ir <= i_rdata;
            if (pc_load) pc <= pc_next;
            if (state == DECODE) begin
                a       <= rs_val;
                b       <= rt_val;
                alu_out <= branch_target;
            end
            if (state == EXEC) alu_out <= alu_result;
            if (mdr_load) mdr <= d_rdata;
            if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
`ifdef MIPS_EXC_EN
            if (epc_load) epc <= pc - 32'd4;
`endif
        end
    end

    // Requests are forced low while reset is held so a pending handshake is dropped.
    assign i_req   = i_req_c & rst_n;
    assign d_req   = d_req_c & rst_n;
    assign d_we    = d_we_c & rst_n;
    assign retire  = retire_c & rst_n;
    assign i_addr  = pc;
    assign d_addr  = alu_out[DMEM_AW+1:2];
    assign d_wdata = b;
`ifdef MIPS_EXC_EN
    assign exc     = exc_c & rst_n;
`endif

endmodule

// File: tb/tb_multicycle_mips.sv
// Directed bench for multicycle_mips: instruction ROM and data RAM models with programmable wait states.
module tb_multicycle_mips;
    import mips_pkg::*;

    localparam int DMEM_AW = 7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_req, i_ready, d_req, d_we, d_ready, retire;
    logic [31:0]        i_addr, i_rdata, d_wdata, d_rdata;
    logic [DMEM_AW-1:0] d_addr;
`ifdef MIPS_EXC_EN
    logic               exc;
`endif

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:127];
    logic        mem_fill = 1'b1;
    logic        d_hold = 1'b0;
    int          i_wait = 0, d_wait = 0;
    int          i_cnt = 0, d_cnt = 0;
    int          checks = 0, errors = 0;

    multicycle_mips #(.DMEM_AW(DMEM_AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .retire  (retire)
`ifdef MIPS_EXC_EN
        ,
        .exc     (exc)
`endif
    );

    always #5 clk = ~clk;

    assign i_rdata = imem[i_addr[9:2]];
    assign i_ready = i_req && (i_cnt >= i_wait);
    assign d_rdata = dmem[d_addr];
    assign d_ready = d_req && !d_hold && (d_cnt >= d_wait);

    always @(posedge clk) begin
        if (!i_req || i_ready) i_cnt <= 0;
        else                   i_cnt <= i_cnt + 1;
        if (!d_req || d_ready) d_cnt <= 0;
        else                   d_cnt <= d_cnt + 1;
        if (mem_fill) begin
            for (int k = 0; k < 128; k++) dmem[k] <= 32'hDEAD_BEEF;
        end else if (d_req && d_we && d_ready) begin
            dmem[d_addr] <= d_wdata;
        end
    end

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input int op, input int addr);
        return {6'(op), 26'(addr >> 2)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
    endtask

    task automatic clear_imem();
        for (int k = 0; k < 256; k++) imem[k] = 32'h0;
    endtask

    // Called in the first cycle of an instruction; ends in the first cycle of the next one.
    task automatic run_instr(input string tag, input int exp_cyc);
        int cyc;
        cyc = 1;
        while (retire !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        check({tag, " retire"}, 32'(retire), 32'd1);
        check({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
        step();
    endtask

    initial begin
        clear_imem();

        // Reset state
        do_reset();
        mem_fill = 1'b0;
        check("rst state", 32'(dut.state), 32'(FETCH));
        check("rst i_addr", i_addr, 32'h0);
        check("rst i_req", 32'(i_req), 32'd0);
        check("rst d_req", 32'(d_req), 32'd0);
        check("rst retire", 32'(retire), 32'd0);

        // Reset while a store waits in MEM
        imem[0] = i_ins(OP_ADDI, 0, 1, 5);
        imem[1] = i_ins(OP_SW, 0, 1, 8);
        d_hold = 1'b1;
        rst_n = 1'b1;
        run_instr("t1 addi", 4);
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            check("t1 sw d_req", 32'(d_req), 32'd1);
            check("t1 sw d_we", 32'(d_we), 32'd1);
            check("t1 sw d_addr", 32'(d_addr), 32'd2);
            check("t1 sw d_wdata", d_wdata, 32'd5);
            step();
        end
        rst_n = 1'b0;
        step();
        check("t1 abort state", 32'(dut.state), 32'(FETCH));
        check("t1 abort i_addr", i_addr, 32'h0);
        check("t1 abort d_req", 32'(d_req), 32'd0);
        check("t1 abort R1", dut.regs[1], 32'h0);
        d_hold = 1'b0;
        step();
        check("t1 abort dmem", dmem[2], 32'hDEAD_BEEF);

        // ALU sequence, zero wait
        clear_imem();
        imem[0] = i_ins(OP_ADDI, 0, 1, 5);
        imem[1] = i_ins(OP_ADDI, 0, 2, -3);
        imem[2] = r_ins(1, 2, 3, 0, FN_ADD);
        imem[3] = r_ins(2, 1, 4, 0, FN_SLT);
        imem[4] = r_ins(1, 2, 11, 0, FN_SLT);
        imem[5] = r_ins(1, 2, 8, 0, FN_SUB);
        imem[6] = r_ins(1, 2, 9, 0, FN_AND);
        imem[7] = r_ins(1, 2, 10, 0, FN_OR);
        imem[8] = r_ins(0, 1, 6, 3, FN_SLL);
        imem[9] = r_ins(0, 2, 7, 28, FN_SRL);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) run_instr($sformatf("t2 ins%0d", k), 4);
        check("t2 R1", dut.regs[1], 32'd5);
        check("t2 R2", dut.regs[2], 32'hFFFF_FFFD);
        check("t2 R3 add", dut.regs[3], 32'd2);
        check("t2 R4 slt", dut.regs[4], 32'd1);
        check("t2 R11 slt", dut.regs[11], 32'd0);
        check("t2 R8 sub", dut.regs[8], 32'd8);
        check("t2 R9 and", dut.regs[9], 32'd5);
        check("t2 R10 or", dut.regs[10], 32'hFFFF_FFFD);
        check("t2 R6 sll", dut.regs[6], 32'h28);
        check("t2 R7 srl", dut.regs[7], 32'hF);

        // Store/load with data wait states, then a fetch wait
        do_reset();
        clear_imem();
        imem[0] = i_ins(OP_ADDI, 0, 1, 5);
        imem[1] = i_ins(OP_SW, 0, 1, 8);
        imem[2] = i_ins(OP_LW, 0, 5, 8);
        imem[3] = i_ins(OP_ADDI, 0, 12, 1);
        d_wait = 3;
        rst_n = 1'b1;
        run_instr("t3 addi", 4);
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            check("t3 sw d_req", 32'(d_req), 32'd1);
            check("t3 sw d_we", 32'(d_we), 32'd1);
            check("t3 sw d_addr", 32'(d_addr), 32'd2);
            check("t3 sw d_wdata", d_wdata, 32'd5);
            check("t3 sw retire", 32'(retire), (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        check("t3 dmem", dmem[2], 32'd5);
        run_instr("t3 lw", 8);
        check("t3 R5", dut.regs[5], 32'd5);
        i_wait = 2;
        run_instr("t3 addi iwait", 6);
        check("t3 R12", dut.regs[12], 32'd1);
        i_wait = 0;
        d_wait = 0;

        // Branches
        do_reset();
        clear_imem();
        imem[0] = i_ins(OP_ADDI, 0, 1, 5);
        imem[1] = i_ins(OP_BNE, 1, 1, 5);
        imem[2] = i_ins(OP_ADDI, 2, 2, 1);
        imem[3] = i_ins(OP_BEQ, 1, 1, -2);
        rst_n = 1'b1;
        run_instr("t4 addi", 4);
        run_instr("t4 bne", 3);
        check("t4 bne pc", i_addr, 32'h8);
        run_instr("t4 addi2", 4);
        run_instr("t4 beq", 3);
        check("t4 beq pc", i_addr, 32'h8);
        run_instr("t4 addi3", 4);
        check("t4 R2", dut.regs[2], 32'd2);

        // Jumps, R0 write, unknown instructions
        do_reset();
        clear_imem();
        imem[0]  = i_ins(OP_ADDI, 0, 0, 7);
        imem[1]  = j_ins(OP_JAL, 32'h40);
        imem[2]  = i_ins(OP_ADDI, 0, 3, 9);
        imem[3]  = j_ins(OP_J, 32'h20);
        imem[8]  = 32'hFC00_0000;
        imem[9]  = r_ins(1, 2, 3, 0, 6'h3F);
        imem[16] = r_ins(31, 0, 0, 0, FN_JR);
        rst_n = 1'b1;
        run_instr("t5 addi r0", 4);
        check("t5 R0", dut.regs[0], 32'h0);
        run_instr("t5 jal", 2);
        check("t5 jal pc", i_addr, 32'h40);
        check("t5 R31", dut.regs[31], 32'h8);
        run_instr("t5 jr", 3);
        check("t5 jr pc", i_addr, 32'h8);
        run_instr("t5 addi", 4);
        check("t5 R3", dut.regs[3], 32'd9);
        run_instr("t5 j", 2);
        check("t5 j pc", i_addr, 32'h20);
`ifdef MIPS_EXC_EN
        check("t6 exc fetch", 32'(exc), 32'd0);
        step();
        check("t6 exc pulse", 32'(exc), 32'd1);
        check("t6 exc retire", 32'(retire), 32'd0);
        step();
        check("t6 exc pc", i_addr, 32'h80);
        check("t6 epc", dut.epc, 32'h20);
        check("t6 exc low", 32'(exc), 32'd0);
`else
        run_instr("t6 bad op", 2);
        check("t6 bad op pc", i_addr, 32'h24);
        check("t6 R3 kept", dut.regs[3], 32'd9);
        run_instr("t6 bad funct", 2);
        check("t6 bad funct pc", i_addr, 32'h28);
        check("t6 R3 still", dut.regs[3], 32'd9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
